// File: rtl/mode_switch_sequencer.sv
// Orders Shell<->Application switches: drain the bus, hold the CPU in reset, flip ownership, release.
// Optional drain watchdog with sticky status bit: define MODE_SEQ_DRAIN_TIMEOUT_EN.
module mode_switch_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        shell_req_app,
    input  logic        shell_req_shell,
    input  logic        cpu_mode_write,
    input  logic [31:0] cpu_mode_wdata,
    input  logic        bus_busy,
    output logic        app_mode,
    output logic        cpu_resetn,
    output logic        cpu_hold,
    output logic        busy,
    output logic        switch_done,
    output logic [31:0] status_rdata
);

    typedef enum logic [1:0] {
        SHELL  = 2'd0,
        APP    = 2'd1,
        DRAIN  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t        state;
    logic [CW-1:0] counter;
    logic          target;
    logic          pend_valid;
    logic          pend_target;
    logic          timeout_flag;
    logic          req_valid;
    logic          req_target;
    logic          eff_valid;
    logic          eff_target;
    logic          drain_exit;

    // A fresh request in a steady cycle supersedes whatever was left pending
    always_comb begin
        req_valid  = 1'b0;
        req_target = 1'b0;
        if (shell_req_app) begin
            req_valid  = 1'b1;
            req_target = 1'b1;
        end else if (shell_req_shell) begin
            req_valid  = 1'b1;
            req_target = 1'b0;
        end else if (cpu_mode_write && state == APP) begin
            req_valid  = 1'b1;
            req_target = cpu_mode_wdata[0];
        end
        eff_valid  = req_valid | pend_valid;
        eff_target = req_valid ? req_target : pend_target;
    end

`ifdef MODE_SEQ_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] drain_count;
    logic          drain_timeout;
    logic          unused_wdata;

    assign drain_timeout = bus_busy && (drain_count == TW'(TIMEOUT_CYCLES - 1));
    assign drain_exit    = !bus_busy || drain_timeout;
    assign unused_wdata  = ^cpu_mode_wdata[31:2];
`else
    logic        unused_wdata;
    logic [31:0] unused_timeout;

    assign drain_exit     = !bus_busy;
    assign timeout_flag   = 1'b0;
    assign unused_wdata   = ^cpu_mode_wdata[31:1];
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= SHELL;
            counter     <= '0;
            target      <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= 1'b0;
            app_mode    <= 1'b0;
            cpu_resetn  <= 1'b0;
            cpu_hold    <= 1'b0;
            busy        <= 1'b0;
            switch_done <= 1'b0;
`ifdef MODE_SEQ_DRAIN_TIMEOUT_EN
            drain_count  <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            switch_done <= 1'b0;
            case (state)
                SHELL, APP: begin
                    pend_valid <= 1'b0;
                    if (eff_valid && (eff_target != (state == APP))) begin
                        state    <= DRAIN;
                        target   <= eff_target;
                        busy     <= 1'b1;
                        cpu_hold <= (state == APP);
`ifdef MODE_SEQ_DRAIN_TIMEOUT_EN
                        drain_count <= '0;
`endif
                    end
`ifdef MODE_SEQ_DRAIN_TIMEOUT_EN
                    if (state == APP && cpu_mode_write && cpu_mode_wdata[1])
                        timeout_flag <= 1'b0;
`endif
                end
                DRAIN: begin
                    if (drain_exit) begin
                        state      <= SETTLE;
                        cpu_resetn <= 1'b0;
                        app_mode   <= target;
                        counter    <= CW'(RST_CYCLES - 1);
                    end
`ifdef MODE_SEQ_DRAIN_TIMEOUT_EN
                    if (drain_timeout)
                        timeout_flag <= 1'b1;
                    else if (bus_busy)
                        drain_count <= drain_count + 1'b1;
`endif
                end
                SETTLE: begin
                    if (counter == '0) begin
                        state       <= target ? APP : SHELL;
                        busy        <= 1'b0;
                        cpu_hold    <= 1'b0;
                        switch_done <= 1'b1;
                        cpu_resetn  <= target;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: state <= SHELL;
            endcase
            if ((state == DRAIN || state == SETTLE) && req_valid) begin
                pend_valid  <= 1'b1;
                pend_target <= req_target;
            end
        end
    end

    assign status_rdata = {26'd0, 2'(state), timeout_flag, pend_valid, busy, app_mode};

endmodule

// File: tb/tb_mode_switch_sequencer.sv
// Directed bench for mode_switch_sequencer: switch latency, priority, pending slot, reset abort, drain wait.
module tb_mode_switch_sequencer;

    logic        clk;
    logic        resetn;
    logic        shell_req_app;
    logic        shell_req_shell;
    logic        cpu_mode_write;
    logic [31:0] cpu_mode_wdata;
    logic        bus_busy;
    logic        app_mode;
    logic        cpu_resetn;
    logic        cpu_hold;
    logic        busy;
    logic        switch_done;
    logic [31:0] status_rdata;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;
    int base_pulses;

    mode_switch_sequencer #(.RST_CYCLES(16), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk),
        .resetn(resetn),
        .shell_req_app(shell_req_app),
        .shell_req_shell(shell_req_shell),
        .cpu_mode_write(cpu_mode_write),
        .cpu_mode_wdata(cpu_mode_wdata),
        .bus_busy(bus_busy),
        .app_mode(app_mode),
        .cpu_resetn(cpu_resetn),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .switch_done(switch_done),
        .status_rdata(status_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (switch_done) done_pulses++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic req_app, input logic req_shell,
                                  input logic wr, input logic [31:0] wdata, input logic bb);
        shell_req_app   = req_app;
        shell_req_shell = req_shell;
        cpu_mode_write  = wr;
        cpu_mode_wdata  = wdata;
        bus_busy        = bb;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        resetn = 1'b0;
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(2);
        resetn = 1'b1;
        tick(10);
        check_output("reset_app_mode", app_mode, 0);
        check_output("reset_cpu_resetn", cpu_resetn, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_cpu_hold", cpu_hold, 0);
        check_output("reset_switch_done", switch_done, 0);
        check_output("reset_status", status_rdata, 32'h0);

        // Shell -> App with an idle bus
        apply_stimulus(1, 0, 0, 32'h0, 0);
        tick(1);
        check_output("s2a_drain_status", status_rdata, 32'h22);
        check_output("s2a_drain_hold", cpu_hold, 0);
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(1);
        check_output("s2a_settle_status", status_rdata, 32'h33);
        check_output("s2a_settle_resetn", cpu_resetn, 0);
        tick(15);
        check_output("s2a_edge17_status", status_rdata, 32'h33);
        check_output("s2a_edge17_done", switch_done, 0);
        tick(1);
        check_output("s2a_edge18_done", switch_done, 1);
        check_output("s2a_edge18_resetn", cpu_resetn, 1);
        check_output("s2a_edge18_status", status_rdata, 32'h11);
        tick(1);
        check_output("s2a_done_one_cycle", switch_done, 0);

        // App -> Shell by CPU write while the bus stays busy
        apply_stimulus(0, 0, 1, 32'h0, 1);
        tick(1);
        check_output("a2s_drain_status", status_rdata, 32'h23);
        check_output("a2s_drain_hold", cpu_hold, 1);
        apply_stimulus(0, 0, 0, 32'h0, 1);
        tick(4);
        check_output("a2s_still_drain", status_rdata, 32'h23);
        check_output("a2s_drain_resetn", cpu_resetn, 1);
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(1);
        check_output("a2s_settle_status", status_rdata, 32'h32);
        check_output("a2s_settle_resetn", cpu_resetn, 0);
        check_output("a2s_settle_hold", cpu_hold, 1);
        tick(15);
        check_output("a2s_edge15_status", status_rdata, 32'h32);
        tick(1);
        check_output("a2s_shell_status", status_rdata, 32'h0);
        check_output("a2s_shell_done", switch_done, 1);
        check_output("a2s_shell_hold", cpu_hold, 0);
        check_output("a2s_shell_resetn", cpu_resetn, 0);

        // CPU write ignored in Shell; Shell request in Shell is a no-op
        apply_stimulus(0, 0, 1, 32'h1, 0);
        tick(1);
        check_output("cpuwr_in_shell", status_rdata, 32'h0);
        apply_stimulus(0, 1, 0, 32'h0, 0);
        tick(1);
        check_output("noop_shell_status", status_rdata, 32'h0);
        check_output("noop_shell_done", switch_done, 0);

        // Both shell requests in one cycle: App wins, nothing pending
        apply_stimulus(1, 1, 0, 32'h0, 0);
        tick(1);
        check_output("both_drain_status", status_rdata, 32'h22);
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(1);
        check_output("both_settle_status", status_rdata, 32'h33);
        tick(16);
        check_output("both_app_status", status_rdata, 32'h11);

        // In App: shell_req_app outranks a CPU write to Shell, giving a no-op
        apply_stimulus(1, 0, 1, 32'h0, 0);
        tick(1);
        check_output("prio_noop_status", status_rdata, 32'h11);
        check_output("prio_noop_done", switch_done, 0);

        // App -> Shell with a redundant pending Shell request, cleared silently
        apply_stimulus(0, 1, 0, 32'h0, 0);
        tick(1);
        check_output("pendnoop_drain", status_rdata, 32'h23);
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(2);
        apply_stimulus(0, 1, 0, 32'h0, 0);
        tick(1);
        check_output("pendnoop_pending", status_rdata, 32'h36);
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(14);
        check_output("pendnoop_arrive", status_rdata, 32'h04);
        check_output("pendnoop_done", switch_done, 1);
        tick(1);
        check_output("pendnoop_cleared", status_rdata, 32'h0);

        // Shell -> App with a pending Shell request: back-to-back transitions
        base_pulses = done_pulses;
        apply_stimulus(1, 0, 0, 32'h0, 0);
        tick(1);
        check_output("pend_drain", status_rdata, 32'h22);
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(2);
        apply_stimulus(0, 1, 0, 32'h0, 0);
        tick(1);
        check_output("pend_captured", status_rdata, 32'h37);
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(14);
        check_output("pend_app_status", status_rdata, 32'h15);
        check_output("pend_app_resetn", cpu_resetn, 1);
        tick(1);
        check_output("pend_second_drain", status_rdata, 32'h23);
        check_output("pend_second_hold", cpu_hold, 1);
        tick(1);
        check_output("pend_second_settle", status_rdata, 32'h32);
        tick(16);
        check_output("pend_final_status", status_rdata, 32'h0);
        check_output("pend_final_done", switch_done, 1);
        tick(1);
        check_output("pend_two_pulses", done_pulses - base_pulses, 2);

        // Reset mid-transition aborts without a done pulse
        base_pulses = done_pulses;
        apply_stimulus(1, 0, 0, 32'h0, 0);
        tick(1);
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(2);
        check_output("abort_in_settle", status_rdata, 32'h33);
        resetn = 1'b0;
        tick(1);
        check_output("abort_status", status_rdata, 32'h0);
        check_output("abort_app_mode", app_mode, 0);
        resetn = 1'b1;
        tick(20);
        check_output("abort_idle_status", status_rdata, 32'h0);
        check_output("abort_no_pulse", done_pulses - base_pulses, 0);

        // Bus stuck busy in DRAIN
        apply_stimulus(1, 0, 0, 32'h0, 1);
        tick(1);
        check_output("stuck_drain", status_rdata, 32'h22);
        apply_stimulus(0, 0, 0, 32'h0, 1);
`ifdef MODE_SEQ_DRAIN_TIMEOUT_EN
        tick(1023);
        check_output("timeout_before", status_rdata, 32'h22);
        tick(1);
        check_output("timeout_forced", status_rdata, 32'h3B);
        tick(16);
        check_output("timeout_app_sticky", status_rdata, 32'h19);
        apply_stimulus(0, 0, 1, 32'h3, 1);
        tick(1);
        check_output("timeout_cleared", status_rdata, 32'h11);
`else
        tick(50);
        check_output("stuck_still_drain", status_rdata, 32'h22);
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(1);
        check_output("stuck_release", status_rdata, 32'h33);
        tick(16);
        check_output("stuck_app", status_rdata, 32'h11);
        apply_stimulus(0, 0, 1, 32'h3, 0);
        tick(1);
        check_output("stuck_cpuwr_noop", status_rdata, 32'h11);
`endif
        apply_stimulus(0, 0, 0, 32'h0, 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mode_switch_sequencer.md
Name: mode_switch_sequencer

Overview:
Sequences every Shell↔Application transition so that bus ownership and CPU reset change in a safe order. Takes switch requests from the shell ('r'/'s' pulses) and from the CPU mode register write. Drains the in-flight bus transaction, holds the CPU in reset for a fixed settle time, flips bus ownership (app_mode), then releases the CPU. Sits between the shell command decoder/MMIO decode and the bus mux plus CPU reset input.

Parameters:
RST_CYCLES, 16, CPU reset hold cycles per transition; legal range ≥1.
TIMEOUT_CYCLES, 1024, drain timeout in cycles; used only with MODE_SEQ_DRAIN_TIMEOUT_EN.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-low reset
shell_req_app  in  1  one-cycle pulse: shell requests App mode
shell_req_shell  in  1  one-cycle pulse: shell requests Shell mode
cpu_mode_write  in  1  CPU write strobe to mode register
cpu_mode_wdata  in  32  CPU write data; only bit 0 is used
bus_busy  in  1  current bus owner has a transaction in flight
app_mode  out  1  bus owner: 0 = Shell, 1 = CPU
cpu_resetn  out  1  CPU reset, active-low
cpu_hold  out  1  stalls new CPU bus requests
busy  out  1  transition in progress
switch_done  out  1  one-cycle pulse when a steady state is entered
status_rdata  out  32  combinational status read word

Behaviour:
- Reset (resetn=0 at a clk edge) values: state=SHELL, app_mode=0, cpu_resetn=0, cpu_hold=0, busy=0, switch_done=0, pending cleared, counter=0, timeout flag=0.
- Reset mid-transition aborts the transition immediately to SHELL; no switch_done pulse.
- States: SHELL, APP, DRAIN, SETTLE. The register `target` holds the destination mode.
- Request decode, same-cycle priority: shell_req_app > shell_req_shell > cpu_mode_write.
  - cpu_mode_write is honoured only in APP (the CPU is in reset otherwise). Elsewhere it is ignored.
  - A request whose target equals the current steady mode is a no-op: no pulse, no state change.
- SHELL or APP with a valid request at edge k:
  - DRAIN at k+1, with target latched.
  - busy=1 from k+1.
  - cpu_hold=1 in DRAIN when leaving APP; otherwise cpu_hold=0.
- DRAIN:
  - If bus_busy=0 is sampled at an edge: go to SETTLE.
  - At that same edge: cpu_resetn←0, app_mode←target, counter←RST_CYCLES−1.
- SETTLE:
  - Counter decrements each cycle.
  - At the edge where counter==0: go to target steady state (SHELL or APP), busy←0, cpu_hold←0, switch_done←1 for one cycle.
  - cpu_resetn←1 at that edge only when target=APP.
- Latency: request at edge k with bus_busy=0 reaches steady state at edge k+2+RST_CYCLES (k+18 at default).
- Requests arriving while busy=1 go into a single-entry pending slot.
  - A later request overwrites the earlier one (last wins; within a cycle the priority above applies).
  - On entering a steady state, a valid pending entry is evaluated as if it were a fresh request in that cycle, then cleared. A no-op pending request is cleared silently.
- cpu_mode_write during busy is ignored, since the CPU is held or in reset.
- status_rdata bits:
  - bit0 = app_mode
  - bit1 = busy
  - bit2 = pending valid
  - bit3 = drain-timeout sticky flag
  - bits[5:4] = state (SHELL=0, APP=1, DRAIN=2, SETTLE=3)
  - bits[31:6] = 0

Optional Feature:
MODE_SEQ_DRAIN_TIMEOUT_EN
- Defined:
  - A counter runs while in DRAIN.
  - If bus_busy stays 1 for TIMEOUT_CYCLES consecutive cycles, DRAIN is forced to SETTLE exactly as if bus_busy were 0, and the sticky status bit3 is set.
  - Bit3 is cleared only by resetn or by a CPU write with wdata[1]=1 in APP.
- Undefined: DRAIN waits indefinitely on bus_busy, and status bit3 reads 0.

Test Plan:
- Reset then idle 10 cycles → app_mode=0, cpu_resetn=0, busy=0, status_rdata=0x00000000.
- SHELL, shell_req_app pulse at edge 0, bus_busy=0, RST_CYCLES=16 → app_mode=1 from edge 2; cpu_resetn=1 and switch_done pulse at edge 18; status_rdata=0x11 after.
- APP, cpu_mode_write wdata=0 while bus_busy=1 for 5 cycles → cpu_hold=1, state DRAIN until bus_busy falls; then cpu_resetn=0, app_mode=0; SHELL reached RST_CYCLES+1 cycles after drain.
- Same cycle shell_req_shell=1 and shell_req_app=1 in SHELL → transition to APP; no pending entry left.
- During SETTLE toward APP, pulse shell_req_shell → status bit2=1; on reaching APP a second transition starts immediately; final state SHELL with two switch_done pulses.
- Timeout build, bus_busy stuck high, TIMEOUT_CYCLES=1024 → forced SETTLE after 1024 DRAIN cycles, status bit3=1; CPU write 0x3 in APP clears bit3.
